coeff_load_ctrl: RTL and testbench

COEFF_LOAD_CTRL -- requirements
Module: coeff_load_ctrl

---
 rtl/coeff_load_ctrl_pkg.sv | 7 +
 rtl/coeff_load_ctrl_bank_sel.sv | 19 +
 rtl/coeff_load_ctrl.sv | 114 +++++++++++
 tb/tb_coeff_load_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/coeff_load_ctrl_pkg.sv
// coeff_load_ctrl_pkg: shared FIR control state encoding, bank count and RAM address width
package coeff_load_ctrl_pkg;
  localparam int NBANKS = 4;
  localparam int BANK_W = 2;
  localparam int ADDR_W = 4;
  typedef enum logic [2:0] {IDLE, WAIT_SMP, ARM, WAIT_DATA, WRITE, FINISH} state_t;
endpackage

// File: rtl/coeff_load_ctrl_bank_sel.sv
// coeff_bank_sel: next selected bank above the current one, or a none-left flag
module coeff_bank_sel
  import coeff_load_ctrl_pkg::*;
(
  input  logic [NBANKS-1:0] mask,
  input  logic [BANK_W-1:0] cur,
  output logic [BANK_W-1:0] nxt,
  output logic              none
);
  always_comb begin
    nxt = cur;
    none = 1'b1;
    for (int i = NBANKS - 1; i >= 0; i--)
      if (BANK_W'(i) > cur && mask[i]) begin
        nxt = BANK_W'(i);
        none = 1'b0;
      end
  end
endmodule

// File: rtl/coeff_load_ctrl.sv
// coeff_load_ctrl: sample-aligned coefficient RAM loader writing host words into selected banks
module coeff_load_ctrl
  import coeff_load_ctrl_pkg::*;
#(
  parameter int TAPS   = 10,
  parameter int DATA_W = 16
) (
  input  logic              iClk_12M,
  input  logic              iRst,
  input  logic              iEnSample600k,
  input  logic              iLoadStart,
  input  logic [3:0]        iBankMask,
  input  logic              iLoadAbort,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffData,
  output logic              oCoeffReady,
  output logic              oUpdateFlag,
  output logic              oCsn_1,
  output logic              oCsn_2,
  output logic              oCsn_3,
  output logic              oCsn_4,
  output logic              oWrn,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oBusy,
  output logic              oLoadDone,
  output logic              oLoadErr
);
  state_t state;
  logic [NBANKS-1:0] mask_q, csn;
  logic [BANK_W-1:0] bank, nxt;
  logic none;
  coeff_bank_sel u_sel (.mask(mask_q), .cur(bank), .nxt(nxt), .none(none));
  assign {oCsn_4, oCsn_3, oCsn_2, oCsn_1} = csn;
  // oAddr is the tap counter itself; it only advances once the WRITE cycle is over
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state <= IDLE;
      mask_q <= '0;
      bank <= '0;
      oAddr <= '0;
      oWrData <= '0;
      csn <= '1;
      oWrn <= 1'b1;
      oUpdateFlag <= 1'b0;
      oCoeffReady <= 1'b0;
      oBusy <= 1'b0;
      oLoadDone <= 1'b0;
      oLoadErr <= 1'b0;
    end else begin
      oLoadDone <= 1'b0;
      oLoadErr <= 1'b0;
      csn <= '1;
      oWrn <= 1'b1;
      if (state != IDLE && iLoadAbort) begin
        state <= IDLE;
        oLoadErr <= 1'b1;
        oUpdateFlag <= 1'b0;
        oCoeffReady <= 1'b0;
        oBusy <= 1'b0;
      end else begin
        case (state)
          IDLE: if (iLoadStart) begin
            if (iBankMask != '0) begin
              mask_q <= iBankMask;
              bank <= '0;
              oAddr <= '0;
              oBusy <= 1'b1;
              state <= WAIT_SMP;
            end else oLoadErr <= 1'b1;
          end
          // bank starts at 0; jump to the lowest set bit if bank 1 is unselected
          WAIT_SMP: if (iEnSample600k) begin
            state <= ARM;
            oUpdateFlag <= 1'b1;
            if (!mask_q[0]) bank <= nxt;
          end
          ARM: begin
            state <= WAIT_DATA;
            oCoeffReady <= 1'b1;
          end
          WAIT_DATA: if (iCoeffValid) begin
            oWrData <= iCoeffData;
            oCoeffReady <= 1'b0;
            csn[bank] <= 1'b0;
            oWrn <= 1'b0;
            state <= WRITE;
          end
          WRITE: if (oAddr == ADDR_W'(TAPS - 1)) begin
            oAddr <= '0;
            if (none) begin
              state <= FINISH;
              oLoadDone <= 1'b1;
            end else begin
              bank <= nxt;
              state <= WAIT_DATA;
              oCoeffReady <= 1'b1;
            end
          end else begin
            oAddr <= oAddr + ADDR_W'(1);
            state <= WAIT_DATA;
            oCoeffReady <= 1'b1;
          end
          FINISH: begin
            state <= IDLE;
            oUpdateFlag <= 1'b0;
            oBusy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_coeff_load_ctrl.sv
// tb_coeff_load_ctrl: randomized and directed checks against a queue-based load model
module tb_coeff_load_ctrl;
  localparam int TAPS = 10, DW = 16;
  localparam int P_IDLE = 0, P_SMP = 1, P_ARM = 2, P_DATA = 3, P_WR = 4, P_FIN = 5;
  logic clk = 0, rst = 1, smp = 0, start = 0, abort = 0, valid = 0;
  logic [3:0] mask = 0;
  logic [DW-1:0] data = 0;
  logic ready, upd, csn1, csn2, csn3, csn4, wrn, busy, done, err;
  logic [3:0] addr;
  logic [DW-1:0] wd;
  wire [3:0] csn = {csn4, csn3, csn2, csn1};
  int checks = 0, failures = 0;
  typedef struct {int b; int a;} wr_t;
  wr_t q[$];
  wr_t cur;
  int ph = P_IDLE;
  logic [DW-1:0] m_wd = 0;
  bit m_err = 0, m_acc = 0, mv = 0;
  int n_wr = 0, n_done = 0, n_err = 0, acc = 0;
  int n_csn[4] = '{default: 0};
  logic [DW-1:0] mem [4][16];
  logic [3:0] ecsn;

  always #5 clk = ~clk;

  coeff_load_ctrl #(.TAPS(TAPS), .DATA_W(DW)) dut (
    .iClk_12M(clk), .iRst(rst), .iEnSample600k(smp), .iLoadStart(start),
    .iBankMask(mask), .iLoadAbort(abort), .iCoeffValid(valid), .iCoeffData(data),
    .oCoeffReady(ready), .oUpdateFlag(upd), .oCsn_1(csn1), .oCsn_2(csn2),
    .oCsn_3(csn3), .oCsn_4(csn4), .oWrn(wrn), .oAddr(addr), .oWrData(wd),
    .oBusy(busy), .oLoadDone(done), .oLoadErr(err));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, act, exp);
    end
  endtask

  // Inputs are held from posedge+1 to the next posedge+1, so at negedge they are what the
  // next edge samples: compare against the current model state, then advance the model.
  always @(negedge clk) begin
    if (mv) begin
      ecsn = (ph == P_WR) ? ~(4'b1 << cur.b) : 4'hF;
      chk("busy", busy, ph != P_IDLE);
      chk("update", upd, ph >= P_ARM);
      chk("ready", ready, ph == P_DATA);
      chk("wrn", wrn, ph != P_WR);
      chk("csn", csn, ecsn);
      chk("done", done, ph == P_FIN);
      chk("err", err, m_err);
      chk("wrdata", wd, m_wd);
      if (ph == P_WR) chk("addr", addr, cur.a);
      if (!wrn) n_wr++;
      if (done) n_done++;
      if (err) n_err++;
      for (int k = 0; k < 4; k++)
        if (!csn[k]) begin
          mem[k][addr] = wd;
          n_csn[k]++;
        end
    end
    m_acc = 0;
    m_err = 0;
    if (rst) begin
      ph = P_IDLE;
      m_wd = '0;
      q.delete();
      mv = 1;
    end else if (ph != P_IDLE && abort) begin
      ph = P_IDLE;
      m_err = 1;
      q.delete();
    end else case (ph)
      P_IDLE: if (start) begin
        if (mask == 0) m_err = 1;
        else begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) for (int a = 0; a < TAPS; a++) q.push_back('{b, a});
          ph = P_SMP;
        end
      end
      P_SMP: if (smp) ph = P_ARM;
      P_ARM: ph = P_DATA;
      P_DATA: if (valid) begin
        cur = q.pop_front();
        m_wd = data;
        m_acc = 1;
        ph = P_WR;
      end
      P_WR: ph = (q.size() == 0) ? P_FIN : P_DATA;
      default: ph = P_IDLE;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (m_acc) begin
      data++;
      acc++;
    end
  endtask

  task automatic run_load(input logic [3:0] m, input int dly, input bit sim,
                          input int stop_after, input int rst_at, input bit rnd);
    int g;
    acc = 0;
    start = 1; mask = m; smp = sim;
    tick();
    start = 0; smp = 0; mask = 4'($urandom);
    repeat (dly) begin
      chk("update_before_strobe", upd, 0);
      tick();
    end
    smp = 1;
    tick();
    smp = 0;
    chk("arm_update", upd, 1);
    chk("arm_ready", ready, 0);
    g = 0;
    while (ph != P_IDLE && g < 400) begin
      valid = (acc < stop_after) && (!rnd || $urandom_range(0, 2) != 0);
      abort = (acc >= stop_after) && (ph == P_DATA);
      rst = (acc == rst_at) && (ph == P_WR);
      if (rst) begin abort = 1; valid = 1; end
      tick();
      rst = 0; abort = 0;
      g++;
    end
    valid = 0;
    chk("load_in_time", g < 400, 1);
  endtask

  initial begin
    int w0, d0, e0, c0, c1, c2, c3, bad;
    rst = 1;
    repeat (3) tick();
    rst = 0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_csn", csn, 4'hF);
    chk("rst_wrn", wrn, 1);
    chk("rst_addr", addr, 0);
    chk("rst_wrdata", wd, 0);
    chk("rst_update", upd, 0);
    // full four-bank load, words 0..39
    data = 0; w0 = n_wr; d0 = n_done;
    run_load(4'hF, 0, 0, 999, 999, 0);
    chk("t1_update_low", upd, 0);
    tick();
    chk("t1_writes", n_wr - w0, 40);
    chk("t1_done", n_done - d0, 1);
    bad = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < TAPS; a++) if (mem[b][a] !== DW'(10 * b + a)) bad++;
    chk("t1_map", bad, 0);
    chk("t1_b4a9", mem[3][9], 39);
    // banks 1 and 3 only, with gaps in valid
    data = 0; w0 = n_wr;
    c0 = n_csn[0]; c1 = n_csn[1]; c2 = n_csn[2]; c3 = n_csn[3];
    run_load(4'h5, 2, 0, 999, 999, 1);
    tick();
    chk("t2_writes", n_wr - w0, 20);
    chk("t2_bank1", n_csn[0] - c0, 10);
    chk("t2_bank2_idle", n_csn[1] - c1, 0);
    chk("t2_bank3", n_csn[2] - c2, 10);
    chk("t2_bank4_idle", n_csn[3] - c3, 0);
    chk("t2_b3a0", mem[2][0], 10);
    chk("t2_b3a9", mem[2][9], 19);
    // empty mask is rejected
    w0 = n_wr; e0 = n_err;
    start = 1; mask = 0;
    tick();
    start = 0;
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);
    tick();
    chk("t3_err_once", err, 0);
    chk("t3_busy2", busy, 0);
    chk("t3_nowrite", n_wr - w0, 0);
    // abort after the 5th word
    data = 0; w0 = n_wr; e0 = n_err;
    run_load(4'h1, 1, 0, 5, 999, 0);
    chk("t4_err", err, 1);
    chk("t4_update", upd, 0);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_writes", n_wr - w0, 5);
    chk("t4_err_count", n_err - e0, 1);
    // sample strobe delayed by 37 cycles, then one coinciding with start
    run_load(4'h2, 37, 0, 999, 999, 1);
    run_load(4'h8, 3, 1, 999, 999, 0);
    // reset during the third WRITE, with abort and valid also high
    data = 0; w0 = n_wr; d0 = n_done; e0 = n_err;
    run_load(4'hF, 0, 0, 999, 3, 0);
    chk("t6_busy", busy, 0);
    chk("t6_csn", csn, 4'hF);
    chk("t6_wrdata", wd, 0);
    chk("t6_update", upd, 0);
    tick();
    chk("t6_writes", n_wr - w0, 3);
    chk("t6_no_pulse", (n_done - d0) + (n_err - e0), 0);
    data = 0; w0 = n_wr; d0 = n_done;
    run_load(4'hF, 1, 0, 999, 999, 0);
    tick();
    chk("t6_reload_writes", n_wr - w0, 40);
    chk("t6_reload_done", n_done - d0, 1);
    chk("t6_reload_b4a9", mem[3][9], 39);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 15) == 0);
      mask = 4'($urandom_range(0, 15));
      smp = ($urandom_range(0, 3) == 0);
      valid = 1'($urandom_range(0, 1));
      data = DW'($urandom);
      abort = ($urandom_range(0, 299) == 0);
      @(posedge clk);
      #1;
    end
    {rst, start, smp, valid, abort} = '0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
